// File: rtl/pipe_cla_pkg.sv
// rtl/pipe_cla_pkg.sv - shared constants, depth helper and stage record for pipe_cla_adder
package pipe_cla_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG_W = 4;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [DEF_WIDTH-1:0] a_hi;
        logic [DEF_WIDTH-1:0] b_hi;
        logic [DEF_WIDTH-1:0] sum_lo;
    } stage_t;

endpackage

// File: rtl/pipe_cla_adder_seg.sv
// rtl/pipe_cla_adder_seg.sv - combinational SEG_W-bit carry-lookahead segment (cla_seg)
module cla_seg #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             c_in,
    output logic [SEG_W-1:0] s,
    output logic             c_out,
    output logic             g_out,
    output logic             p_out
);

    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    logic             prod;
    logic             grp;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        prod = 1'b0;
        grp  = 1'b0;
        c[0] = c_in;
        // Each carry is a flat sum of generate terms gated by the propagates above them.
        for (int i = 0; i < SEG_W; i++) begin
            c[i+1] = g[i];
            prod   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (prod & c_in);
        end
        for (int i = 0; i < SEG_W; i++) begin
            grp = g[i] | (p[i] & grp);
        end
        s     = p ^ c[SEG_W-1:0];
        c_out = c[SEG_W];
        g_out = grp;
        p_out = &p;
    end

endmodule

// File: rtl/pipe_cla_adder.sv
// rtl/pipe_cla_adder.sv - pipelined segmented CLA adder, one segment per stage, valid/ready stall
// Optional PIPE_CLA_SUB_EN adds in_sub (a-b) and out_ovf (signed overflow).
module pipe_cla_adder
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPE_CLA_SUB_EN
    input  logic             in_sub,
    output logic             out_ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NSEG = nseg(WIDTH, SEG_W);

    if ((WIDTH % SEG_W) != 0 || WIDTH < SEG_W) begin : g_bad_width
        $error("pipe_cla_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic [WIDTH-1:0] sum_lo;
    } stage_rec_t;

    stage_rec_t       st_q   [NSEG];
    stage_rec_t       st_d   [NSEG];
    logic [WIDTH-1:0] opa    [NSEG];
    logic [WIDTH-1:0] opb    [NSEG];
    logic [WIDTH-1:0] sum_in [NSEG];
    logic             cin    [NSEG];
    logic             vin    [NSEG];
    logic [SEG_W-1:0] seg_s  [NSEG];
    logic             seg_c  [NSEG];
    logic             seg_g  [NSEG];
    logic             seg_p  [NSEG];
    logic             stall;

    // Stage k consumes what stage k-1 registered; stage 0 sees the input port directly.
    always_comb begin
        stall     = st_q[NSEG-1].valid & ~out_ready;
        opa[0]    = in_a;
        opb[0]    = in_b;
        cin[0]    = in_cin;
`ifdef PIPE_CLA_SUB_EN
        opb[0]    = in_sub ? ~in_b : in_b;
        cin[0]    = in_sub | in_cin;
`endif
        sum_in[0] = '0;
        vin[0]    = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            opa[k]    = st_q[k-1].a_hi;
            opb[k]    = st_q[k-1].b_hi;
            cin[k]    = st_q[k-1].carry;
            sum_in[k] = st_q[k-1].sum_lo;
            vin[k]    = st_q[k-1].valid;
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        cla_seg #(.SEG_W(SEG_W)) u_seg (
            .a     (opa[k][k*SEG_W +: SEG_W]),
            .b     (opb[k][k*SEG_W +: SEG_W]),
            .c_in  (cin[k]),
            .s     (seg_s[k]),
            .c_out (seg_c[k]),
            .g_out (seg_g[k]),
            .p_out (seg_p[k])
        );
    end

    // Data only moves with valid tokens, so bubbles never disturb the held output value.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            st_d[k] = st_q[k];
            if (!stall) begin
                st_d[k].valid = vin[k];
                if (vin[k]) begin
                    st_d[k].a_hi   = opa[k];
                    st_d[k].b_hi   = opb[k];
                    st_d[k].carry  = seg_c[k];
                    st_d[k].sum_lo = sum_in[k];
                    st_d[k].sum_lo[k*SEG_W +: SEG_W] = seg_s[k];
                end
            end
        end
    end

`ifdef PIPE_CLA_SUB_EN
    logic out_ovf_q;
    logic out_ovf_d;

    always_comb begin
        out_ovf_d = out_ovf_q;
        if (!stall && vin[NSEG-1]) begin
            out_ovf_d = (opa[NSEG-1][WIDTH-1] == opb[NSEG-1][WIDTH-1]) &&
                        (seg_s[NSEG-1][SEG_W-1] != opa[NSEG-1][WIDTH-1]);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                st_q[k] <= '0;
            end
`ifdef PIPE_CLA_SUB_EN
            out_ovf_q <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                st_q[k] <= st_d[k];
            end
`ifdef PIPE_CLA_SUB_EN
            out_ovf_q <= out_ovf_d;
`endif
        end
    end

    // Group generate/propagate must agree with the segment's own carry chain.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSEG; k++) begin
            if (rst_n) begin
                assert (seg_c[k] == (seg_g[k] | (seg_p[k] & cin[k])));
            end
        end
    end

    assign in_ready  = ~stall;
    assign out_valid = st_q[NSEG-1].valid;
    assign out_sum   = st_q[NSEG-1].sum_lo;
    assign out_cout  = st_q[NSEG-1].carry;
`ifdef PIPE_CLA_SUB_EN
    assign out_ovf   = out_ovf_q;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb/tb_pipe_cla_adder.sv - self-checking bench for pipe_cla_adder (WIDTH=16, SEG_W=4)
module tb_pipe_cla_adder;

    localparam int W = 16;
    localparam int S = 4;
    localparam int N = W / S;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_cin    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef PIPE_CLA_SUB_EN
    logic         in_sub    = 1'b0;
    logic         out_ovf;
`endif

    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int n_out        = 0;
    int last_out_cyc = 0;

    logic [W:0] exp_q     [$];
    logic       exp_ovf_q [$];

    pipe_cla_adder #(.WIDTH(W), .SEG_W(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef PIPE_CLA_SUB_EN
        .in_sub    (in_sub),
        .out_ovf   (out_ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: arithmetic reference on accept, in-order compare on every output transfer.
    always @(negedge clk) begin : mon
        logic [W:0] e;
        logic       eo;
        int         r;
        if (!rst_n) begin
            exp_q.delete();
            exp_ovf_q.delete();
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_output");
                end else begin
                    e  = exp_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    check("sb_sum", 32'(out_sum), 32'(e[W-1:0]));
                    check("sb_cout", 32'(out_cout), 32'(e[W]));
`ifdef PIPE_CLA_SUB_EN
                    check("sb_ovf", 32'(out_ovf), 32'(eo));
`endif
                    n_out++;
                    last_out_cyc = cyc;
                end
            end
            if (in_valid && in_ready) begin
                e = {1'b0, in_a} + {1'b0, in_b} + (W+1)'(in_cin);
                r = int'($signed(in_a)) + int'($signed(in_b)) + int'(in_cin);
`ifdef PIPE_CLA_SUB_EN
                if (in_sub) begin
                    e = {1'b0, in_a} + {1'b0, ~in_b} + (W+1)'(1);
                    r = int'($signed(in_a)) - int'($signed(in_b));
                end
`endif
                eo = (r > 32767) || (r < -32768);
                exp_q.push_back(e);
                exp_ovf_q.push_back(eo);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int   guard;
        logic acc;
        guard    = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        do begin
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 100);
        if (!acc) fail("send_timeout");
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int g;
        g = 0;
        while (!out_valid && g < 100) begin
            tick();
            g++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int cyc0;
        int n0;
        int g;

        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Test 1: latency and carry ripple across three segments
        out_ready = 1'b1;
        send(16'h0FFF, 16'h0001, 1'b0);
        tick();
        tick();
        check("t1_not_yet_valid", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid_at_latency", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(out_sum), 32'h1000);
        check("t1_cout", 32'(out_cout), 32'd0);
        tick();

        // Test 2: wraparound carry-out cases
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_out("t2a_wait");
        check("t2a_sum", 32'(out_sum), 32'h0000);
        check("t2a_cout", 32'(out_cout), 32'd1);
        tick();
        send(16'hFFFF, 16'hFFFF, 1'b1);
        wait_out("t2b_wait");
        check("t2b_sum", 32'(out_sum), 32'hFFFF);
        check("t2b_cout", 32'(out_cout), 32'd1);
        tick();

        // Test 3: 100 back-to-back ops at full throughput
        cyc0 = cyc;
        n0   = n_out;
        for (int i = 0; i < 100; i++) begin
            in_a     = (i == 0) ? 16'hFFFF : W'($urandom);
            in_b     = (i == 0) ? 16'h0000 : W'($urandom);
            in_cin   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < N + 2; i++) tick();
        check("t3_count", 32'(n_out - n0), 32'd100);
        check("t3_last_cycle", 32'(last_out_cyc), 32'(cyc0 + 99 + N));

        // Test 4: random back-pressure with a 10-cycle hold
        for (int i = 0; i < 200; i++) begin
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_cin    = 1'($urandom_range(0, 1));
            in_valid  = (i >= 55 && i < 70) ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready = (i >= 60 && i < 70) ? 1'b0 : 1'($urandom_range(0, 1));
            if (i == 66) begin
                check("t4_stall_out_valid", 32'(out_valid), 32'd1);
                check("t4_stall_in_ready", 32'(in_ready), 32'd0);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            tick();
            g++;
        end
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Test 5: asynchronous reset with ops in flight
        in_valid = 1'b1;
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
        tick();
        in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b1;
        tick();
        in_a = 16'h7000; in_b = 16'h7000; in_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_sum", 32'(out_sum), 32'h3333);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_sum", 32'(out_sum), 32'd0);
        check("t5_async_cout", 32'(out_cout), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_rel_in_ready", 32'(in_ready), 32'd1);
        check("t5_rel_valid", 32'(out_valid), 32'd0);
        send(16'h1234, 16'h4321, 1'b0);
        tick();
        tick();
        check("t5_new_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("t5_new_valid", 32'(out_valid), 32'd1);
        check("t5_new_sum", 32'(out_sum), 32'h5555);
        tick();

`ifdef PIPE_CLA_SUB_EN
        // Test 6: subtraction and signed overflow
        in_sub = 1'b1;
        send(16'h8000, 16'h0001, 1'b0);
        wait_out("t6a_wait");
        check("t6a_sum", 32'(out_sum), 32'h7FFF);
        check("t6a_cout", 32'(out_cout), 32'd1);
        check("t6a_ovf", 32'(out_ovf), 32'd1);
        tick();
        send(16'h0003, 16'h0005, 1'b1);
        wait_out("t6b_wait");
        check("t6b_sum", 32'(out_sum), 32'hFFFE);
        check("t6b_cout", 32'(out_cout), 32'd0);
        check("t6b_ovf", 32'(out_ovf), 32'd0);
        tick();
        in_sub = 1'b0;
`endif

        for (int i = 0; i < N + 2; i++) tick();
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
